// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the two-requester data-memory arbiter.
package dmem_arb_pkg;

   localparam int DEF_ADDR_WIDTH = 10;
   localparam int DEF_COL_WIDTH  = 8;
   localparam int DEF_NB_COL     = 4;
   localparam int N_REQ          = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_e;

   typedef logic req_idx_t;

   function automatic logic [1:0] idx_onehot(input req_idx_t idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/dmem_rr_arb2.sv
// Two-way round-robin selector with a one-requester lock; owns last_grant and lock_owner.
module dmem_rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_valid,
   input  logic [1:0] req_lock,
   input  logic       free,
   output logic       gnt_vld,
   output logic       gnt_id
);

   req_idx_t last_grant_q, last_grant_d;
   logic     lock_vld_q, lock_vld_d;
   req_idx_t lock_id_q, lock_id_d;
   logic     cand_vld;
   req_idx_t cand_id;

   always_comb begin
      cand_vld = 1'b0;
      cand_id  = 1'b0;
      // A held lock masks the other requester completely
      if (lock_vld_q) begin
         cand_vld = req_valid[lock_id_q];
         cand_id  = lock_id_q;
      end else if (&req_valid) begin
         cand_vld = 1'b1;
         cand_id  = ~last_grant_q;
      end else if (req_valid[1]) begin
         cand_vld = 1'b1;
         cand_id  = 1'b1;
      end else if (req_valid[0]) begin
         cand_vld = 1'b1;
         cand_id  = 1'b0;
      end

      gnt_vld = cand_vld & free;
      gnt_id  = cand_id;

      last_grant_d = last_grant_q;
      lock_vld_d   = lock_vld_q;
      lock_id_d    = lock_id_q;
      if (gnt_vld) begin
         last_grant_d = cand_id;
         lock_vld_d   = req_lock[cand_id];
         lock_id_d    = cand_id;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
         lock_vld_q   <= 1'b0;
         lock_id_q    <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
         lock_vld_q   <= lock_vld_d;
         lock_id_q    <= lock_id_d;
      end
   end

endmodule

// File: rtl/dmem_arb.sv
// Arbitrates two load/store requesters onto one single-port data memory,
// holding one registered response at a time.
//
//   state   | meaning
//   --------+-------------------------------------------
//   ST_IDLE | no response held
//   ST_RESP | one response held for the rsp_valid holder
module dmem_arb
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int COL_WIDTH  = DEF_COL_WIDTH,
   parameter int NB_COL     = DEF_NB_COL
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [1:0]                     req_valid,
   output logic [1:0]                     req_ready,
   input  logic [1:0]                     req_wr,
   input  logic [1:0]                     req_lock,
   input  logic [2*ADDR_WIDTH-1:0]        req_addr,
   input  logic [2*NB_COL-1:0]            req_be,
   input  logic [2*NB_COL*COL_WIDTH-1:0]  req_wdata,
   output logic [1:0]                     rsp_valid,
   input  logic [1:0]                     rsp_ready,
   output logic [NB_COL*COL_WIDTH-1:0]    rsp_data,
   output logic                           mem_valid_st,
   output logic                           mem_spec_ld,
   output logic [NB_COL-1:0]              mem_we,
   output logic [ADDR_WIDTH-1:0]          mem_addr,
   output logic [NB_COL*COL_WIDTH-1:0]    mem_din,
   input  logic [NB_COL*COL_WIDTH-1:0]    mem_dout
);

   localparam int DW = NB_COL * COL_WIDTH;

   state_e          state_q, state_d;
   logic [1:0]      rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]   rsp_data_q, rsp_data_d;

   logic            handoff;
   logic            free;
   logic            gnt_vld;
   req_idx_t        gnt_id;
   logic            sel_wr;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [NB_COL-1:0]     sel_be;
   logic [DW-1:0]         sel_wdata;

   // rst_n gates acceptance so no strobe escapes while reset is asserted
   assign handoff = |(rsp_valid_q & rsp_ready);
   assign free    = rst_n & ((state_q == ST_IDLE) | handoff);

   dmem_rr_arb2 u_rr_arb2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_lock  (req_lock),
      .free      (free),
      .gnt_vld   (gnt_vld),
      .gnt_id    (gnt_id)
   );

   assign sel_wr    = req_wr[gnt_id];
   assign sel_addr  = gnt_id ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
   assign sel_be    = gnt_id ? req_be[2*NB_COL-1:NB_COL] : req_be[NB_COL-1:0];
   assign sel_wdata = gnt_id ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];

   always_comb begin
      req_ready    = 2'b00;
      mem_valid_st = 1'b0;
      mem_spec_ld  = 1'b0;
      mem_we       = '0;
      mem_addr     = '0;
      mem_din      = '0;
      if (gnt_vld) begin
         req_ready = idx_onehot(gnt_id);
         mem_addr  = sel_addr;
         if (sel_wr) begin
            mem_valid_st = 1'b1;
            mem_we       = sel_be;
            mem_din      = sel_wdata;
         end else begin
            mem_spec_ld  = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      if (gnt_vld) begin
         state_d     = ST_RESP;
         rsp_valid_d = idx_onehot(gnt_id);
         rsp_data_d  = sel_wr ? '0 : mem_dout;
      end else if (handoff) begin
         state_d     = ST_IDLE;
         rsp_valid_d = 2'b00;
         rsp_data_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rsp_valid_q <= 2'b00;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_dmem_arb.sv
// Self-checking bench for dmem_arb: directed vector table, reset corner case,
// and randomized traffic against a transaction-level reference model.
module tb_dmem_arb;

   localparam int AW = 10;
   localparam int DW = 32;

   logic          clk;
   logic          rst_n;
   logic [1:0]    req_valid, req_ready, req_wr, req_lock;
   logic [2*AW-1:0] req_addr;
   logic [7:0]    req_be;
   logic [2*DW-1:0] req_wdata;
   logic [1:0]    rsp_valid, rsp_ready;
   logic [DW-1:0] rsp_data;
   logic          mem_valid_st, mem_spec_ld;
   logic [3:0]    mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din, mem_dout;

   dmem_arb dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_lock(req_lock),
      .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .mem_valid_st(mem_valid_st), .mem_spec_ld(mem_spec_ld), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] init_val(input int i);
      if (i == 5)  return 32'hDEADBEEF;
      if (i == 16) return 32'hFFFFFFFF;
      return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
   endfunction

   // Environment memory, written only through the DUT's memory port
   logic [31:0] env_mem [0:1023];
   logic        init_done;
   assign mem_dout = env_mem[mem_addr];

   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 1024; i++) env_mem[i] <= init_val(i);
      end else if (mem_valid_st) begin
         for (int b = 0; b < 4; b++)
            if (mem_we[b]) env_mem[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
      end
   end

   // Reference model: who holds a response, what it carries, and the arbitration history
   logic [31:0] ref_mem [0:1023];
   bit          m_hold_vld;
   int          m_hold_id;
   logic [31:0] m_hold_data;
   int          m_last;
   bit          m_lock_vld;
   int          m_lock_id;

   int checks = 0;
   int errors = 0;
   logic [1:0] sampled_ready;

   typedef struct {
      logic [1:0]  valid, wr, lock;
      logic [9:0]  addr0, addr1;
      logic [3:0]  be0, be1;
      logic [31:0] wd0, wd1;
      logic [1:0]  rdy;
      logic [1:0]  exp_ready, exp_rv;
      logic [31:0] exp_rd;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_hold_vld = 0;
      m_hold_id  = 0;
      m_last     = 1;
      m_lock_vld = 0;
      m_lock_id  = 0;
   endtask

   function automatic vec_t mk(input logic [1:0] valid, wr, lock, input logic [9:0] a0, a1,
                               input logic [3:0] be0, be1, input logic [31:0] wd0, wd1,
                               input logic [1:0] rdy, er, erv, input logic [31:0] erd);
      vec_t v;
      v.valid = valid; v.wr = wr; v.lock = lock; v.addr0 = a0; v.addr1 = a1;
      v.be0 = be0; v.be1 = be1; v.wd0 = wd0; v.wd1 = wd1; v.rdy = rdy;
      v.exp_ready = er; v.exp_rv = erv; v.exp_rd = erd;
      return v;
   endfunction

   // One clock cycle: check held response, drive, check acceptance outputs, advance model
   task automatic step(input vec_t v);
      int          g;
      bit          free, g_wr, g_ld;
      logic [9:0]  a;
      logic [3:0]  be;
      logic [31:0] wd;
      @(negedge clk);
      chk("rsp_valid", {62'd0, rsp_valid}, m_hold_vld ? (64'd1 << m_hold_id) : 64'd0);
      if (m_hold_vld) chk("rsp_data", {32'd0, rsp_data}, {32'd0, m_hold_data});
      req_valid = v.valid; req_wr = v.wr; req_lock = v.lock;
      req_addr  = {v.addr1, v.addr0}; req_be = {v.be1, v.be0};
      req_wdata = {v.wd1, v.wd0}; rsp_ready = v.rdy;
      #1;
      g = -1;
      free = !m_hold_vld || v.rdy[m_hold_id];
      if (free) begin
         if (m_lock_vld) begin
            if (v.valid[m_lock_id]) g = m_lock_id;
         end else if (v.valid == 2'b11) g = 1 - m_last;
         else if (v.valid[0]) g = 0;
         else if (v.valid[1]) g = 1;
      end
      a  = (g == 1) ? v.addr1 : v.addr0;
      be = (g == 1) ? v.be1 : v.be0;
      wd = (g == 1) ? v.wd1 : v.wd0;
      g_wr = (g >= 0) && v.wr[g];
      g_ld = (g >= 0) && !v.wr[g];
      chk("req_ready", {62'd0, req_ready}, (g < 0) ? 64'd0 : (64'd1 << g));
      chk("mem_valid_st", {63'd0, mem_valid_st}, {63'd0, g_wr});
      chk("mem_spec_ld", {63'd0, mem_spec_ld}, {63'd0, g_ld});
      chk("mem_we", {60'd0, mem_we}, g_wr ? {60'd0, be} : 64'd0);
      chk("mem_addr", {54'd0, mem_addr}, (g >= 0) ? {54'd0, a} : 64'd0);
      if (!g_ld) chk("mem_din", {32'd0, mem_din}, g_wr ? {32'd0, wd} : 64'd0);
      sampled_ready = req_ready;
      if (m_hold_vld && v.rdy[m_hold_id]) m_hold_vld = 0;
      if (g >= 0) begin
         m_hold_vld  = 1;
         m_hold_id   = g;
         m_hold_data = g_wr ? 32'd0 : ref_mem[a];
         if (g_wr)
            for (int b = 0; b < 4; b++)
               if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
         m_last     = g;
         m_lock_vld = v.lock[g];
         m_lock_id  = g;
      end
      @(posedge clk);
      #1;
   endtask

   vec_t tbl[$];
   vec_t v;

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
      model_reset();
      init_done = 1'b0;
      rst_n = 1'b0;
      req_valid = 2'b00; req_wr = 2'b00; req_lock = 2'b00;
      req_addr = '0; req_be = '0; req_wdata = '0; rsp_ready = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rsp_valid", {62'd0, rsp_valid}, 64'd0);
      chk("reset_rsp_data", {32'd0, rsp_data}, 64'd0);
      req_valid = 2'b11;
      #1;
      chk("reset_req_ready", {62'd0, req_ready}, 64'd0);
      chk("reset_mem_ld", {63'd0, mem_spec_ld}, 64'd0);
      chk("reset_mem_addr", {54'd0, mem_addr}, 64'd0);
      req_valid = 2'b00;
      @(negedge clk);
      init_done = 1'b1;
      rst_n = 1'b1;

      //          valid  wr     lock   a0     a1     be0   be1   wd0           wd1           rdy    ready  rv     rd
      tbl.push_back(mk(2'b01, 2'b00, 2'b00, 10'h005, 10'h000, 4'h0, 4'h0, 32'h0,         32'h0,         2'b00, 2'b01, 2'b01, 32'hDEADBEEF));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 4'h0, 4'h0, 32'h0,         32'h0,         2'b01, 2'b00, 2'b00, 32'h0));
      tbl.push_back(mk(2'b10, 2'b10, 2'b00, 10'h000, 10'h010, 4'h0, 4'h3, 32'h0,         32'h12345678,  2'b00, 2'b10, 2'b10, 32'h0));
      tbl.push_back(mk(2'b10, 2'b00, 2'b00, 10'h000, 10'h010, 4'h0, 4'h0, 32'h0,         32'h0,         2'b10, 2'b10, 2'b10, 32'hFFFF5678));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 4'h0, 4'h0, 32'h0,         32'h0,         2'b10, 2'b00, 2'b00, 32'h0));
      for (int k = 0; k < 2; k++) begin
         tbl.push_back(mk(2'b11, 2'b00, 2'b00, 10'h005, 10'h010, 4'h0, 4'h0, 32'h0, 32'h0, 2'b11, 2'b01, 2'b01, 32'hDEADBEEF));
         tbl.push_back(mk(2'b11, 2'b00, 2'b00, 10'h005, 10'h010, 4'h0, 4'h0, 32'h0, 32'h0, 2'b11, 2'b10, 2'b10, 32'hFFFF5678));
      end
      for (int k = 0; k < 3; k++)
         tbl.push_back(mk(2'b11, 2'b00, 2'b00, 10'h005, 10'h010, 4'h0, 4'h0, 32'h0, 32'h0, 2'b00, 2'b00, 2'b10, 32'hFFFF5678));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 4'h0, 4'h0, 32'h0,         32'h0,         2'b10, 2'b00, 2'b00, 32'h0));
      tbl.push_back(mk(2'b11, 2'b00, 2'b01, 10'h005, 10'h010, 4'h0, 4'h0, 32'h0,         32'h0,         2'b00, 2'b01, 2'b01, 32'hDEADBEEF));
      tbl.push_back(mk(2'b11, 2'b00, 2'b00, 10'h005, 10'h010, 4'h0, 4'h0, 32'h0,         32'h0,         2'b01, 2'b01, 2'b01, 32'hDEADBEEF));
      tbl.push_back(mk(2'b11, 2'b00, 2'b00, 10'h005, 10'h010, 4'h0, 4'h0, 32'h0,         32'h0,         2'b01, 2'b10, 2'b10, 32'hFFFF5678));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 4'h0, 4'h0, 32'h0,         32'h0,         2'b10, 2'b00, 2'b00, 32'h0));
      tbl.push_back(mk(2'b01, 2'b01, 2'b00, 10'h005, 10'h000, 4'h0, 4'h0, 32'hAAAAAAAA,  32'h0,         2'b00, 2'b01, 2'b01, 32'h0));
      tbl.push_back(mk(2'b01, 2'b00, 2'b00, 10'h005, 10'h000, 4'h0, 4'h0, 32'h0,         32'h0,         2'b01, 2'b01, 2'b01, 32'hDEADBEEF));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 4'h0, 4'h0, 32'h0,         32'h0,         2'b01, 2'b00, 2'b00, 32'h0));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 4'h0, 4'h0, 32'h0,         32'h0,         2'b11, 2'b00, 2'b00, 32'h0));
      tbl.push_back(mk(2'b01, 2'b00, 2'b00, 10'h005, 10'h000, 4'h0, 4'h0, 32'h0,         32'h0,         2'b00, 2'b01, 2'b01, 32'hDEADBEEF));
      tbl.push_back(mk(2'b01, 2'b00, 2'b00, 10'h005, 10'h000, 4'h0, 4'h0, 32'h0,         32'h0,         2'b10, 2'b00, 2'b01, 32'hDEADBEEF));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 4'h0, 4'h0, 32'h0,         32'h0,         2'b01, 2'b00, 2'b00, 32'h0));

      foreach (tbl[i]) begin
         step(tbl[i]);
         chk($sformatf("tbl%0d_ready", i), {62'd0, sampled_ready}, {62'd0, tbl[i].exp_ready});
         chk($sformatf("tbl%0d_rsp_valid", i), {62'd0, rsp_valid}, {62'd0, tbl[i].exp_rv});
         if (tbl[i].exp_rv != 2'b00)
            chk($sformatf("tbl%0d_rsp_data", i), {32'd0, rsp_data}, {32'd0, tbl[i].exp_rd});
      end

      // Reset while a response is held: drops it at once, no memory side effects
      step(mk(2'b01, 2'b00, 2'b00, 10'h005, 10'h000, 4'h0, 4'h0, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00, 32'h0));
      chk("pre_rst_rsp_valid", {62'd0, rsp_valid}, 64'd1);
      @(negedge clk);
      req_valid = 2'b01; req_wr = 2'b01; req_addr = {10'h000, 10'h020};
      req_be = 8'h0F; req_wdata = {32'h0, 32'h0BADF00D}; rsp_ready = 2'b00;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
      chk("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
      chk("rst_req_ready", {62'd0, req_ready}, 64'd0);
      chk("rst_mem_st", {63'd0, mem_valid_st}, 64'd0);
      chk("rst_mem_we", {60'd0, mem_we}, 64'd0);
      model_reset();
      @(posedge clk);
      #1;
      chk("rst_hold_mem_st", {63'd0, mem_valid_st}, 64'd0);
      rst_n = 1'b1;
      step(mk(2'b11, 2'b00, 2'b00, 10'h005, 10'h020, 4'h0, 4'h0, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00, 32'h0));
      chk("post_rst_accept", {62'd0, sampled_ready}, 64'd1);
      step(mk(2'b10, 2'b00, 2'b00, 10'h000, 10'h020, 4'h0, 4'h0, 32'h0, 32'h0, 2'b01, 2'b00, 2'b00, 32'h0));
      chk("post_rst_no_store", {32'd0, rsp_data}, {32'd0, init_val(32)});

      // Randomized traffic with a small address range to force read-after-write hits
      for (int n = 0; n < 600; n++) begin
         v.valid = 2'($urandom_range(0, 3));
         v.wr    = 2'($urandom_range(0, 3));
         v.lock  = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
         v.addr0 = 10'($urandom_range(0, 15));
         v.addr1 = 10'($urandom_range(0, 15));
         v.be0   = 4'($urandom_range(0, 15));
         v.be1   = 4'($urandom_range(0, 15));
         v.wd0   = $urandom;
         v.wd1   = $urandom;
         v.rdy   = 2'($urandom_range(0, 3));
         v.exp_ready = 2'b00; v.exp_rv = 2'b00; v.exp_rd = 32'h0;
         step(v);
      end
      for (int n = 0; n < 3; n++)
         step(mk(2'b00, 2'b00, 2'b00, 10'h0, 10'h0, 4'h0, 4'h0, 32'h0, 32'h0, 2'b11, 2'b00, 2'b00, 32'h0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
